// File: rtl/maze_round_ctrl.sv
// Maze game round controller.
// Sequences a round (idle -> arm -> run -> win/lose), drives the seconds timer's
// clear/run controls, records the best completion time as BCD digits, and
// requests a beep of BEEP_CYCLES clocks whenever a round ends.
// Optional build macro: MAZE_ROUND_CTRL_WALL_PENALTY_EN enables a wall-hit
// counter that loses the round after MAX_WALL_HITS collisions.
module maze_round_ctrl #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BEEP_CYCLES     = CLOCK_FREQUENCY / 4,
  parameter int MAX_WALL_HITS   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       goal_reached,
  input  logic       wall_hit,
  input  logic       time_up,
  input  logic [3:0] bcd_ones,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_hundreds,
  output logic       timer_clear,
  output logic       timer_run,
  output logic [1:0] state,
  output logic [3:0] best_ones,
  output logic [3:0] best_tens,
  output logic [3:0] best_hundreds,
  output logic       best_valid,
  output logic       new_record,
  output logic       beep
);

  localparam int BW = $clog2(BEEP_CYCLES + 1);
  localparam logic [BW-1:0] BEEP_LOAD = BW'(BEEP_CYCLES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_WIN  = 3'd3;
  localparam logic [2:0] S_LOSE = 3'd4;

  logic [2:0]    fsm_q, fsm_d;
  logic          start_q, start_d;
  logic          timer_clear_q, timer_clear_d;
  logic          timer_run_q, timer_run_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    best_h_q, best_h_d;
  logic [3:0]    best_t_q, best_t_d;
  logic [3:0]    best_o_q, best_o_d;
  logic          best_valid_q, best_valid_d;
  logic          new_record_q, new_record_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic          beep_q, beep_d;
  logic          start_rise;
  logic          better;
  logic          wall_lose;

`ifdef MAZE_ROUND_CTRL_WALL_PENALTY_EN
  logic [3:0] wall_cnt_q, wall_cnt_d;

  // Wall collisions counted only while running; saturates, cleared on arm.
  always_comb begin
    wall_cnt_d = wall_cnt_q;
    if (fsm_q == S_ARM) begin
      wall_cnt_d = 4'd0;
    end else if (fsm_q == S_RUN && wall_hit && wall_cnt_q != 4'd15) begin
      wall_cnt_d = wall_cnt_q + 4'd1;
    end
  end

  assign wall_lose = (wall_cnt_q >= 4'(MAX_WALL_HITS));

  // Wall counter register.
  always_ff @(posedge clk) begin
    if (reset) wall_cnt_q <= 4'd0;
    else       wall_cnt_q <= wall_cnt_d;
  end
`else
  logic unused_wall;
  assign unused_wall = wall_hit | (MAX_WALL_HITS == 0);
  assign wall_lose   = 1'b0;
`endif

  // Round sequencing, best-time capture and beep timing.
  always_comb begin
    start_rise    = start_btn & ~start_q;
    start_d       = start_btn;
    fsm_d         = fsm_q;
    best_h_d      = best_h_q;
    best_t_d      = best_t_q;
    best_o_d      = best_o_q;
    best_valid_d  = best_valid_q;
    new_record_d  = 1'b0;
    beep_cnt_d    = beep_cnt_q;
    // Concatenated digits compare hundreds first, then tens, then ones.
    better = ~best_valid_q ||
             ({bcd_hundreds, bcd_tens, bcd_ones} < {best_h_q, best_t_q, best_o_q});

    case (fsm_q)
      S_IDLE: if (start_rise) fsm_d = S_ARM;
      S_ARM:  fsm_d = S_RUN;
      S_RUN: begin
        if (goal_reached) begin
          fsm_d = S_WIN;
          if (better) begin
            best_h_d     = bcd_hundreds;
            best_t_d     = bcd_tens;
            best_o_d     = bcd_ones;
            best_valid_d = 1'b1;
            new_record_d = 1'b1;
          end
        end else if (time_up || wall_lose) begin
          fsm_d = S_LOSE;
        end
      end
      S_WIN, S_LOSE: if (start_rise) fsm_d = S_ARM;
      default: fsm_d = S_IDLE;
    endcase

    if (fsm_q == S_RUN && (fsm_d == S_WIN || fsm_d == S_LOSE)) begin
      beep_cnt_d = BEEP_LOAD;
    end else if (fsm_d == S_ARM) begin
      beep_cnt_d = '0;
    end else if (beep_cnt_q != '0) begin
      beep_cnt_d = beep_cnt_q - 1'b1;
    end
    beep_d = (beep_cnt_d != '0);

    // Timer controls and reported state follow the next FSM state so they are registered.
    timer_clear_d = (fsm_d == S_ARM);
    timer_run_d   = (fsm_d == S_RUN);
    case (fsm_d)
      S_ARM, S_RUN: state_d = 2'd1;
      S_WIN:        state_d = 2'd2;
      S_LOSE:       state_d = 2'd3;
      default:      state_d = 2'd0;
    endcase
  end

  // State and output registers; timer is held clear while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q         <= S_IDLE;
      start_q       <= 1'b0;
      timer_clear_q <= 1'b1;
      timer_run_q   <= 1'b0;
      state_q       <= 2'd0;
      best_h_q      <= 4'd9;
      best_t_q      <= 4'd9;
      best_o_q      <= 4'd9;
      best_valid_q  <= 1'b0;
      new_record_q  <= 1'b0;
      beep_cnt_q    <= '0;
      beep_q        <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      start_q       <= start_d;
      timer_clear_q <= timer_clear_d;
      timer_run_q   <= timer_run_d;
      state_q       <= state_d;
      best_h_q      <= best_h_d;
      best_t_q      <= best_t_d;
      best_o_q      <= best_o_d;
      best_valid_q  <= best_valid_d;
      new_record_q  <= new_record_d;
      beep_cnt_q    <= beep_cnt_d;
      beep_q        <= beep_d;
    end
  end

  assign timer_clear   = timer_clear_q;
  assign timer_run     = timer_run_q;
  assign state         = state_q;
  assign best_hundreds = best_h_q;
  assign best_tens     = best_t_q;
  assign best_ones     = best_o_q;
  assign best_valid    = best_valid_q;
  assign new_record    = new_record_q;
  assign beep          = beep_q;

endmodule
